// File: rtl/sdram_cmd_arbiter.sv
// N-port command arbiter feeding the EasySDRAM command input from show-ahead FIFOs.
// Tiered selection (urgent, starved, row-hit/write-grouped, row-miss) with round-robin ties.
module sdram_cmd_arbiter #(
    parameter int NPORTS        = 4,
    parameter int ADDR_W        = 25,
    parameter int DATA_W        = 16,
    parameter int ROW_LSB       = 10,
    parameter int USEDW_W       = 8,
    parameter int URGENT_THRESH = 200,
    parameter int STARVE_LIMIT  = 64,
    parameter int RD2WR_GAP     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPORTS-1:0]          port_en,
    input  logic [NPORTS-1:0]          req_valid,
    input  logic [NPORTS-1:0]          req_write,
    input  logic [NPORTS*ADDR_W-1:0]   req_addr,
    input  logic [NPORTS*DATA_W-1:0]   req_data,
    input  logic [NPORTS*USEDW_W-1:0]  req_usedw,
    output logic [NPORTS-1:0]          req_ack,
    input  logic                       cmd_full,
    output logic                       cmd_valid,
    output logic                       cmd_write,
    output logic [ADDR_W-1:0]          cmd_addr,
    output logic [DATA_W-1:0]          cmd_data,
    output logic [$clog2(NPORTS)-1:0]  cmd_port
);

    localparam int PW     = $clog2(NPORTS);
    localparam int ROW_W  = ADDR_W - ROW_LSB;
    localparam int AGE_W  = $clog2(STARVE_LIMIT + 1);
    localparam int TA_W   = $clog2(RD2WR_GAP + 2);
    localparam int NTIERS = 6;

    localparam logic [USEDW_W-1:0] URG_T    = USEDW_W'(URGENT_THRESH);
    localparam logic [AGE_W-1:0]   STARVE_T = AGE_W'(STARVE_LIMIT);
    localparam logic [TA_W-1:0]    GAP_T    = TA_W'(RD2WR_GAP);

    logic              last_write;
    logic [ROW_W-1:0]  present_row;
    logic [PW-1:0]     rr_ptr;
    logic [TA_W-1:0]   ta_cnt;
    logic [AGE_W-1:0]  age [NPORTS];

    logic [ADDR_W-1:0] addr_a [NPORTS];
    logic [DATA_W-1:0] data_a [NPORTS];
    logic [NPORTS-1:0] elig;
    logic [NPORTS-1:0] urgent;
    logic [NPORTS-1:0] starved;
    logic [NPORTS-1:0] row_hit;
    logic [NPORTS-1:0] wr_grp;
    logic [NPORTS-1:0] wr_ok_v;
    logic [NPORTS-1:0] tier [NTIERS];
    logic [NPORTS-1:0] win_mask;
    logic              grant;
    logic [PW-1:0]     gnt_idx;
    logic [PW-1:0]     rr_next;

    // First set bit of m at or after ptr, wrapping modulo NPORTS.
    function automatic logic [PW-1:0] rr_pick(input logic [NPORTS-1:0] m,
                                              input logic [PW-1:0]     ptr);
        logic [PW-1:0] pick;
        logic [PW-1:0] idx;
        pick = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NPORTS);
            if (m[idx]) pick = idx;
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
            data_a[i]  = req_data[i*DATA_W +: DATA_W];
            urgent[i]  = req_usedw[i*USEDW_W +: USEDW_W] > URG_T;
            starved[i] = age[i] >= STARVE_T;
            row_hit[i] = req_addr[i*ADDR_W+ROW_LSB +: ROW_W] == present_row;
        end
    end

    assign elig    = port_en & req_valid;
    assign wr_grp  = row_hit & {NPORTS{last_write}};
    assign wr_ok_v = {NPORTS{ta_cnt == '0}};

    // Row-hit writes after a read fall into the row-miss write tier so they are never stranded.
    always_comb begin
        tier[0] = elig & urgent;
        tier[1] = elig & starved;
        tier[2] = elig & req_write & wr_grp & wr_ok_v;
        tier[3] = elig & ~req_write & row_hit;
        tier[4] = elig & req_write & ~wr_grp & wr_ok_v;
        tier[5] = elig & ~req_write & ~row_hit;
        win_mask = '0;
        for (int t = NTIERS - 1; t >= 0; t--) begin
            if (|tier[t]) win_mask = tier[t];
        end
    end

    assign grant   = rst & ~cmd_full & (|win_mask);
    assign gnt_idx = rr_pick(win_mask, rr_ptr);
    assign rr_next = (gnt_idx == PW'(NPORTS - 1)) ? '0 : gnt_idx + 1'b1;
    assign req_ack = grant ? (NPORTS'(1) << gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_valid   <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_addr    <= '0;
            cmd_data    <= '0;
            cmd_port    <= '0;
            last_write  <= 1'b1;
            present_row <= '0;
            rr_ptr      <= '0;
            ta_cnt      <= '0;
            for (int i = 0; i < NPORTS; i++) age[i] <= '0;
        end else begin
            cmd_valid <= grant;
            if (grant) begin
                cmd_write   <= req_write[gnt_idx];
                cmd_addr    <= addr_a[gnt_idx];
                cmd_data    <= req_write[gnt_idx] ? data_a[gnt_idx] : '0;
                cmd_port    <= gnt_idx;
                present_row <= addr_a[gnt_idx][ADDR_W-1:ROW_LSB];
                last_write  <= req_write[gnt_idx];
                rr_ptr      <= rr_next;
            end
            if (grant && !req_write[gnt_idx]) begin
                ta_cnt <= GAP_T;
            end else if (ta_cnt != '0) begin
                ta_cnt <= ta_cnt - 1'b1;
            end
            for (int i = 0; i < NPORTS; i++) begin
                if (!elig[i] || (grant && gnt_idx == PW'(i))) begin
                    age[i] <= '0;
                end else if (age[i] != STARVE_T) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: reset, row grouping, turnaround, urgency,
// starvation and backpressure with a per-port FIFO scoreboard.
module tb_sdram_cmd_arbiter;

    localparam int NP = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int UW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    port_en, req_valid, req_write, req_ack;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_data;
    logic [NP*UW-1:0] req_usedw;
    logic             cmd_full, cmd_valid, cmd_write;
    logic [AW-1:0]    cmd_addr;
    logic [DW-1:0]    cmd_data;
    logic [1:0]       cmd_port;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdram_cmd_arbiter #(
        .NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ROW_LSB(10), .USEDW_W(UW),
        .URGENT_THRESH(200), .STARVE_LIMIT(64), .RD2WR_GAP(3)
    ) dut (
        .clk(clk), .rst(rst), .port_en(port_en), .req_valid(req_valid),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .req_usedw(req_usedw), .req_ack(req_ack), .cmd_full(cmd_full),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_port(cmd_port)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [AW-1:0] ra(input int row, input int col);
        return AW'(row * 1024 + col);
    endfunction

    task automatic set_port(input int i, input logic v, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [UW-1:0] u);
        req_valid[i]         = v;
        req_write[i]         = w;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req_usedw[i*UW +: UW] = u;
    endtask

    task automatic clear_all();
        req_valid = '0;
    endtask

    // Scoreboard state for the backpressure phase
    logic [AW-1:0] q_addr [NP][3];
    logic [DW-1:0] q_data [NP][3];
    logic          q_wr   [NP][3];
    int            hd     [NP];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, n0, n1, bp_cmds, pops, cmds, g, h;
        logic          exp_pend, exp_wr, drained;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_port;

        rst = 1'b0; port_en = '1; req_valid = '0; req_write = '0;
        req_addr = '0; req_data = '0; req_usedw = '0; cmd_full = 1'b0;

        // Reset with every port requesting
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b1, ra(0, i), DW'(16'h1000 + i), 8'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_ack", req_ack, 0);
            chk("rst_vld", cmd_valid, 0);
        end
        rst = 1'b1;
        settle();
        chk("first_ack", req_ack, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        chk("first_vld", cmd_valid, 1);
        chk("first_port", cmd_port, 0);
        chk("first_addr", cmd_addr, ra(0, 0));
        chk("first_data", cmd_data, 16'h1000);
        chk("first_wr", cmd_write, 1);
        settle();
        chk("rr_ack", req_ack, 4'b0010);
        tick();
        clear_all();
        chk("rr_port", cmd_port, 1);
        chk("rr_data", cmd_data, 16'h1001);
        tick();
        chk("idle_vld", cmd_valid, 0);

        // Row grouping: open row 5, then row hit beats row miss
        set_port(0, 1'b1, 1'b1, ra(5, 0), 16'hA000, 8'd0);
        settle();
        chk("open_ack", req_ack, 4'b0001);
        tick();
        clear_all();
        set_port(1, 1'b1, 1'b1, ra(5, 1), 16'hA001, 8'd0);
        set_port(2, 1'b1, 1'b1, ra(9, 2), 16'hA002, 8'd0);
        settle();
        chk("hit_ack", req_ack, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        chk("hit_addr", cmd_addr, ra(5, 1));
        settle();
        chk("miss_ack", req_ack, 4'b0100);
        tick();
        clear_all();
        chk("miss_addr", cmd_addr, ra(9, 2));
        set_port(3, 1'b1, 1'b1, ra(5, 3), 16'hA003, 8'd0);
        set_port(0, 1'b1, 1'b1, ra(9, 0), 16'hA004, 8'd0);
        settle();
        chk("hit_over_rr", req_ack, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        settle();
        chk("after_hit_ack", req_ack, 4'b1000);
        tick();
        clear_all();
        chk("after_hit_port", cmd_port, 3);

        // Read -> write turnaround
        set_port(0, 1'b1, 1'b0, ra(5, 16), 16'hBEEF, 8'd0);
        settle();
        chk("rd_ack", req_ack, 4'b0001);
        tick();
        clear_all();
        set_port(1, 1'b1, 1'b1, ra(5, 17), 16'hC001, 8'd0);
        chk("rd_write", cmd_write, 0);
        chk("rd_data", cmd_data, 0);
        chk("rd_addr", cmd_addr, ra(5, 16));
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk($sformatf("ta_t%0d", k), req_ack, (k == 4) ? 4'b0010 : 4'b0000);
            if (k < 4) tick();
        end
        tick();
        clear_all();
        chk("ta_wr", cmd_write, 1);
        chk("ta_data", cmd_data, 16'hC001);

        // Urgency threshold, port enable, cmd_full (combinational only, no edge)
        set_port(3, 1'b1, 1'b0, ra(7, 3), 16'h0, 8'd201);
        set_port(0, 1'b1, 1'b1, ra(5, 32), 16'hD000, 8'd0);
        settle();
        chk("urg_201", req_ack, 4'b1000);
        req_usedw[3*UW +: UW] = 8'd200;
        settle();
        chk("urg_200", req_ack, 4'b0001);
        port_en[0] = 1'b0;
        settle();
        chk("dis_p0", req_ack, 4'b1000);
        cmd_full = 1'b1;
        settle();
        chk("full_ack", req_ack, 0);
        cmd_full = 1'b0;
        port_en = '1;
        clear_all();
        tick();
        chk("no_cmd", cmd_valid, 0);

        // Starvation: p2 row-miss read against streaming row-hit writes
        set_port(0, 1'b1, 1'b1, ra(5, 40), 16'hE000, 8'd0);
        set_port(1, 1'b1, 1'b1, ra(5, 41), 16'hE001, 8'd0);
        set_port(2, 1'b1, 1'b0, ra(9, 42), 16'hE002, 8'd0);
        waited = 0; n0 = 0; n1 = 0;
        for (int w = 1; w <= 80; w++) begin
            settle();
            if (req_ack[2]) begin
                waited = w;
                break;
            end
            if (req_ack[0]) n0++;
            if (req_ack[1]) n1++;
            tick();
        end
        chk("starve_wait", waited, 65);
        chk("starve_p0", n0, 32);
        chk("starve_p1", n1, 32);
        tick();
        clear_all();
        chk("starve_port", cmd_port, 2);
        chk("starve_wr", cmd_write, 0);
        repeat (4) tick();

        // Backpressure and scoreboard drain
        for (int i = 0; i < NP; i++) begin
            hd[i] = 0;
            for (int j = 0; j < 3; j++) begin
                q_addr[i][j] = ra(3 + j, 16 * i + j);
                q_data[i][j] = DW'(16'h5000 + 16 * i + j);
                q_wr[i][j]   = ((i + j) % 2) == 0;
            end
        end
        exp_pend = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_data = '0; exp_port = '0;
        bp_cmds = 0; pops = 0; cmds = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (exp_pend) begin
                chk("sb_vld", cmd_valid, 1);
                chk("sb_addr", cmd_addr, exp_addr);
                chk("sb_data", cmd_data, exp_data);
                chk("sb_port", cmd_port, exp_port);
                chk("sb_wr", cmd_write, exp_wr);
                if (cmd_valid) cmds++;
            end else begin
                chk("sb_idle_vld", cmd_valid, 0);
            end
            if (cyc >= 1 && cyc <= 11 && cmd_valid) bp_cmds++;
            exp_pend = 1'b0;
            drained = 1'b1;
            for (int i = 0; i < NP; i++) if (hd[i] < 3) drained = 1'b0;
            if (cyc > 11 && drained) break;
            cmd_full = (cyc >= 1 && cyc <= 10);
            for (int i = 0; i < NP; i++) begin
                h = (hd[i] < 3) ? hd[i] : 0;
                set_port(i, hd[i] < 3, q_wr[i][h], q_addr[i][h], q_data[i][h], 8'd0);
            end
            settle();
            if (cmd_full) chk("bp_ack", req_ack, 0);
            if (req_ack != '0) begin
                chk("ack_onehot", $onehot(req_ack), 1);
                g = 0;
                for (int k = NP - 1; k >= 0; k--) if (req_ack[k]) g = k;
                chk("ack_valid", req_valid[g], 1);
                if (hd[g] < 3) begin
                    exp_pend = 1'b1;
                    exp_wr   = q_wr[g][hd[g]];
                    exp_addr = q_addr[g][hd[g]];
                    exp_data = q_wr[g][hd[g]] ? q_data[g][hd[g]] : '0;
                    exp_port = 2'(g);
                    hd[g]++;
                    pops++;
                end
            end
            tick();
        end
        cmd_full = 1'b0;
        clear_all();
        chk("bp_at_most_1", bp_cmds <= 1, 1);
        chk("bp_pops", pops, 12);
        chk("bp_cmds", cmds, 12);

        // Reset mid-stream drops the grant and restores row 0 / last_write
        set_port(0, 1'b1, 1'b1, ra(3, 0), 16'hF000, 8'd0);
        set_port(1, 1'b1, 1'b1, ra(0, 1), 16'hF001, 8'd0);
        rst = 1'b0;
        settle();
        chk("rst_mid_ack", req_ack, 0);
        tick();
        chk("rst_mid_vld", cmd_valid, 0);
        chk("rst_mid_addr", cmd_addr, 0);
        rst = 1'b1;
        settle();
        chk("rst_row_ack", req_ack, 4'b0010);
        tick();
        clear_all();
        chk("rst_row_port", cmd_port, 1);
        chk("rst_row_data", cmd_data, 16'hF001);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
